// File: rtl/rr_tristate_bus_mux_pkg.sv
// Shared definitions for the round-robin tri-state bus mux family.
//   clog2    : ceiling log2, used to size channel indices and counters
//   state_t  : bus ownership FSM encoding (IDLE / DRIVE / TURN)
package rr_tristate_bus_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1, callers clamp to 1 where needed.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_tristate_bus_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : per-channel request bits
//   ptr : index of the most recently granted channel; search starts at ptr+1
//   en  : grant enable; gnt stays all-zero while low
//   gnt : one-hot grant (all-zero when en=0 or no request)
//   w   : winning index, valid whenever any req bit is set
module rr_arbiter
  import rr_tristate_bus_mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = (clog2(NCH) > 0) ? clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] w
);

  logic found;

  always_comb begin
    int idx;
    logic [SELW-1:0] sel;
    w     = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    // Walk ptr+1, ptr+2, ... wrapping at NCH; the last index visited is ptr
    // itself, so a lone requester is always re-granted.
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      sel = SELW'(idx);
      if (!found && req[sel]) begin
        found = 1'b1;
        w     = sel;
      end
    end
    gnt = '0;
    if (en && found) gnt[w] = 1'b1;
  end

endmodule

// File: rtl/rr_tristate_bus_mux.sv
// Round-robin NCH:1 mux driving a shared tri-state bus.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-channel request
//   data     : flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   oe       : global output enable; low forces the bus to Z
//   gnt      : one-hot accept; data[i] captured on the edge where gnt[i]=1
//   bus      : shared tri-state bus, driven only while valid=1
//   valid    : bus carries a driven word
//   owner    : channel whose word is on the bus / last granted
// Each accepted word is driven for HOLD enabled cycles. A change of owner
// inserts one undriven turnaround cycle; a repeat grant to the same owner
// continues without a gap.
module rr_tristate_bus_mux
  import rr_tristate_bus_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int HOLD  = 1,
  localparam int SELW = (clog2(NCH) > 0) ? clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*WIDTH-1:0] data,
  input  logic               oe,
  output logic [NCH-1:0]     gnt,
  inout  wire  [WIDTH-1:0]   bus,
  output logic               valid,
  output logic [SELW-1:0]    owner
);

  localparam int CNTW = (clog2(HOLD) > 0) ? clog2(HOLD) : 1;

  state_t          state_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [WIDTH-1:0] data_reg;
  logic [SELW-1:0] ptr_reg;

  logic [WIDTH-1:0] chan [NCH];
  logic [SELW-1:0]  w;
  logic             arb_en;
  logic             decide;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign chan[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // A decision is allowed from IDLE, or in DRIVE once the hold count has
  // run out. rst gates the grant so nothing is accepted while in reset.
  assign arb_en = !rst && oe &&
                  ((state_reg == ST_IDLE) ||
                   (state_reg == ST_DRIVE && cnt_reg == '0));

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req (req),
    .ptr (ptr_reg),
    .en  (arb_en),
    .gnt (gnt),
    .w   (w)
  );

  assign decide = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      ptr_reg   <= SELW'(NCH - 1);
      owner     <= '0;
    end else begin
      if (decide) begin
        data_reg <= chan[w];
        ptr_reg  <= w;
        cnt_reg  <= CNTW'(HOLD - 1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (decide) begin
            state_reg <= ST_DRIVE;
            owner     <= w;
          end
        end
        ST_DRIVE: begin
          if (cnt_reg != '0) begin
            // Hold count only advances while the word is actually on the bus.
            if (oe) cnt_reg <= cnt_reg - 1'b1;
          end else if (decide) begin
            if (w != owner) begin
              state_reg <= ST_TURN;
              owner     <= w;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_TURN:  state_reg <= ST_DRIVE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Combinational oe gating so the bus releases in the same cycle oe falls;
  // rst forces release immediately as well.
  assign valid = !rst && (state_reg == ST_DRIVE) && oe;
  assign bus   = valid ? data_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_rr_tristate_bus_mux.sv
module tb_rr_tristate_bus_mux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int HOLD  = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_DRIVE = 1;
  localparam int PH_TURN  = 2;

  logic               clk;
  logic               rst;
  logic [NCH-1:0]     req;
  logic [NCH*WIDTH-1:0] data;
  logic               oe;
  wire  [NCH-1:0]     gnt;
  wire  [WIDTH-1:0]   bus;
  wire                valid;
  wire  [1:0]         owner;

  rr_tristate_bus_mux #(.WIDTH(WIDTH), .NCH(NCH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .oe    (oe),
    .gnt   (gnt),
    .bus   (bus),
    .valid (valid),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]   gnt;
    logic             valid;
    logic [WIDTH-1:0] word;
    logic [1:0]       owner;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  bit mon_on     = 0;

  logic [WIDTH-1:0] d [NCH];

  // Reference model: phase, remaining enabled drive cycles, last granted,
  // current owner and the captured word.
  int               m_ph;
  int               m_rem;
  int               m_ptr;
  int               m_owner;
  logic [WIDTH-1:0] m_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph    = PH_IDLE;
    m_rem   = 0;
    m_ptr   = NCH - 1;
    m_owner = 0;
    m_word  = '0;
  endtask

  // Compute expected outputs for the current cycle, queue them, then advance
  // the model across the coming clock edge.
  task automatic m_eval();
    exp_t e;
    bit   allow;
    bit   found;
    int   w;
    bit   dec;
    if (rst) begin
      m_reset();
      e.gnt = '0; e.valid = 1'b0; e.word = '0; e.owner = 2'd0;
      exp_q.push_back(e);
      return;
    end
    allow = (m_ph == PH_IDLE) || (m_ph == PH_DRIVE && m_rem == 1);
    found = 0;
    w = 0;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (m_ptr + k) % NCH;
      if (!found && req[idx]) begin
        found = 1;
        w = idx;
      end
    end
    dec = oe && allow && found;
    e.gnt   = dec ? NCH'(1 << w) : '0;
    e.valid = (m_ph == PH_DRIVE) && oe;
    e.word  = m_word;
    e.owner = 2'(m_owner);
    exp_q.push_back(e);

    if (dec) begin
      m_word = d[w];
      m_ptr  = w;
      m_rem  = HOLD;
      if (m_ph == PH_IDLE) begin
        m_ph = PH_DRIVE;
        m_owner = w;
      end else if (w != m_owner) begin
        m_ph = PH_TURN;
        m_owner = w;
      end
    end else if (m_ph == PH_DRIVE) begin
      if (m_rem > 1) begin
        if (oe) m_rem--;
      end else begin
        m_ph = PH_IDLE;
      end
    end else if (m_ph == PH_TURN) begin
      m_ph = PH_DRIVE;
    end
  endtask

  task automatic cycle(input logic r, input logic [NCH-1:0] rq, input logic o);
    @(posedge clk);
    #1;
    rst = r;
    req = rq;
    oe  = o;
    for (int i = 0; i < NCH; i++) data[i*WIDTH +: WIDTH] = d[i];
    m_eval();
    mon_on = 1;
  endtask

  // Monitor: one expected record per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        check("exp_queue_underflow", 32'd0, 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("valid", 32'(valid), 32'(e.valid));
        check("owner", 32'(owner), 32'(e.owner));
        if (e.valid) check("bus", 32'(bus), 32'(e.word));
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; oe = 1'b0; data = '0;
    for (int i = 0; i < NCH; i++) d[i] = '0;
    m_reset();

    // Reset held, then single request from channel 0.
    d[0] = 8'hA5;
    cycle(1'b1, 4'b0001, 1'b1);
    cycle(1'b1, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0001, 1'b1);
    for (int i = 0; i < HOLD + 2; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Round robin with all channels requesting.
    for (int i = 0; i < NCH; i++) d[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 22; i++) cycle(1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Single channel back-to-back.
    d[2] = 8'h5A;
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

    // oe drop after the first drive cycle.
    d[0] = 8'h3C;
    cycle(1'b0, 4'b0001, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);

    // Reset during TURN with 8'h77 pending.
    d[0] = 8'h11; d[1] = 8'h77;
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
        cycle(1'b0, 4'b0011, 1'b1);
        if (m_ph == PH_TURN && m_word == 8'h77) hit = 1;
      end
      check("turn_reached", 32'(hit), 32'd1);
    end
    cycle(1'b1, 4'b0011, 1'b1);
    d[1] = 8'h00;
    cycle(1'b0, 4'b0110, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Late request drop: req[1] only during its grant cycle.
    d[1] = 8'hC3;
    cycle(1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < HOLD + 2; i++) cycle(1'b0, 4'b0000, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic o;
      for (int c = 0; c < NCH; c++) d[c] = 8'($urandom);
      r = ($urandom_range(0, 99) == 0);
      o = ($urandom_range(0, 7) != 0);
      cycle(r, 4'($urandom), o);
    end
    cycle(1'b0, 4'b0000, 1'b1);

    @(negedge clk);
    #1;
    mon_on = 0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
